// File: rtl/restaurant_order_scheduler_pkg.sv
// Shared kitchen state encoding, the "no item" code and the price / cook-time helpers
// used by the restaurant order scheduler.
package restaurant_order_scheduler_pkg;

  typedef enum logic [1:0] {
    K_IDLE = 2'd0,
    K_COOK = 2'd1,
    K_DONE = 2'd2
  } kitchen_state_t;

  localparam int unsigned ITEM_NONE = 0;

  function automatic int unsigned price_of(input int unsigned item, input int unsigned step);
    return item * step;
  endfunction

  function automatic int unsigned cook_cycles(input int unsigned item, input int unsigned step);
    return item * step;
  endfunction

endpackage

// File: rtl/restaurant_order_scheduler_order_fifo.sv
// Per-table order FIFO: simultaneous push and pop are both performed, occupancy exported.
module order_fifo #(
  parameter  int unsigned WIDTH = 2,
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_pop_data,
  output logic [CW-1:0]    o_count,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full     = (r_count == CW'(DEPTH));
  assign o_empty    = (r_count == '0);
  assign w_push     = i_push && !o_full;
  assign w_pop      = i_pop && !o_empty;
  assign o_pop_data = r_mem[r_rptr];
  assign o_count    = r_count;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_push_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/restaurant_order_scheduler.sv
// Restaurant order front-end: per-table FIFOs, bills and shared item stock feeding one
// round-robin kitchen engine whose cook time depends on the item.
module restaurant_order_scheduler
  import restaurant_order_scheduler_pkg::*;
#(
  parameter  int unsigned NUM_TABLES  = 4,
  parameter  int unsigned ITEM_W      = 2,
  parameter  int unsigned QUEUE_DEPTH = 8,
  parameter  int unsigned BILL_W      = 10,
  parameter  int unsigned STOCK_W     = 4,
  parameter  int unsigned INIT_STOCK  = 6,
  parameter  int unsigned PRICE_STEP  = 5,
  parameter  int unsigned COOK_STEP   = 4,
  localparam int unsigned CW          = $clog2(QUEUE_DEPTH + 1)
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_TABLES*ITEM_W-1:0] table_order_item,
  input  logic [NUM_TABLES-1:0]        table_order_valid,
  input  logic [NUM_TABLES-1:0]        table_checkout,
  input  logic                         restock_valid,
  input  logic [ITEM_W-1:0]            restock_item,
  input  logic [STOCK_W-1:0]           restock_qty,
  output logic [NUM_TABLES-1:0]        table_order_reject,
  output logic [NUM_TABLES*BILL_W-1:0] table_bill,
  output logic [NUM_TABLES*CW-1:0]     table_queue_size,
  output logic [NUM_TABLES-1:0]        table_item_ready,
  output logic [ITEM_W-1:0]            ready_item,
  output logic                         kitchen_busy
);

  localparam int unsigned NUM_ITEMS = 1 << ITEM_W;
  localparam int unsigned TW        = (NUM_TABLES > 1) ? $clog2(NUM_TABLES) : 1;
  localparam int unsigned CKW       = $clog2((NUM_ITEMS - 1) * COOK_STEP + 1);

  logic [1:0]            r_rst_sync;
  logic                  w_rst_n;

  logic [ITEM_W-1:0]     w_item     [NUM_TABLES];
  logic [BILL_W-1:0]     w_price    [NUM_TABLES];
  logic [BILL_W:0]       w_bill_sum [NUM_TABLES];
  logic [ITEM_W-1:0]     w_head     [NUM_TABLES];
  logic [CW-1:0]         w_count    [NUM_TABLES];
  logic [NUM_TABLES-1:0] w_full;
  logic [NUM_TABLES-1:0] w_empty;
  logic [NUM_TABLES-1:0] w_accept;
  logic [NUM_TABLES-1:0] w_pop;

  logic [STOCK_W-1:0]    r_stock     [NUM_ITEMS];
  logic [STOCK_W-1:0]    w_stock_nxt [NUM_ITEMS];
  logic [STOCK_W:0]      w_restock_sum;
  logic [BILL_W-1:0]     r_bill      [NUM_TABLES];
  logic [NUM_TABLES-1:0] r_reject;

  kitchen_state_t        r_state;
  kitchen_state_t        w_state_nxt;
  logic [TW-1:0]         r_rr;
  logic [TW-1:0]         r_serve;
  logic [ITEM_W-1:0]     r_item;
  logic [CKW-1:0]        r_cook_cnt;
  logic                  w_grant_valid;
  logic [TW-1:0]         w_grant;
  int unsigned           w_idx;

  // Assert asynchronously, release two clocks after reset_n rises.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_rst_sync <= '0;
    else          r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  for (genvar t = 0; t < NUM_TABLES; t++) begin : g_table
    assign w_item[t]     = table_order_item[t*ITEM_W +: ITEM_W];
    assign w_price[t]    = BILL_W'(price_of(32'(w_item[t]), PRICE_STEP));
    assign w_bill_sum[t] = {1'b0, r_bill[t]} + {1'b0, w_price[t]};
    assign table_bill[t*BILL_W +: BILL_W] = r_bill[t];
    assign table_queue_size[t*CW +: CW]   = w_count[t];

    order_fifo #(
      .WIDTH(ITEM_W),
      .DEPTH(QUEUE_DEPTH)
    ) u_fifo (
      .clk        (clk),
      .reset_n    (w_rst_n),
      .i_push     (w_accept[t]),
      .i_push_data(w_item[t]),
      .i_pop      (w_pop[t]),
      .o_pop_data (w_head[t]),
      .o_count    (w_count[t]),
      .o_full     (w_full[t]),
      .o_empty    (w_empty[t])
    );
  end

  // Tables are walked in index order against a running stock copy so lower indices win
  // contention; restock is applied on top of the same-cycle takes.
  always_comb begin
    w_accept      = '0;
    w_restock_sum = '0;
    for (int unsigned k = 0; k < NUM_ITEMS; k++) w_stock_nxt[k] = r_stock[k];
    for (int unsigned t = 0; t < NUM_TABLES; t++) begin
      if (table_order_valid[t] && (w_item[t] != ITEM_W'(ITEM_NONE)) && !w_full[t] &&
          (w_stock_nxt[w_item[t]] != '0)) begin
        w_accept[t]             = 1'b1;
        w_stock_nxt[w_item[t]]  = w_stock_nxt[w_item[t]] - 1'b1;
      end
    end
    if (restock_valid && (restock_item != ITEM_W'(ITEM_NONE))) begin
      w_restock_sum = {1'b0, w_stock_nxt[restock_item]} + {1'b0, restock_qty};
      w_stock_nxt[restock_item] = w_restock_sum[STOCK_W] ? '1 : w_restock_sum[STOCK_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      for (int unsigned k = 0; k < NUM_ITEMS; k++) r_stock[k] <= STOCK_W'(INIT_STOCK);
      for (int unsigned t = 0; t < NUM_TABLES; t++) r_bill[t] <= '0;
      r_reject <= '0;
    end else begin
      for (int unsigned k = 0; k < NUM_ITEMS; k++) r_stock[k] <= w_stock_nxt[k];
      for (int unsigned t = 0; t < NUM_TABLES; t++) begin
        if (table_checkout[t])
          r_bill[t] <= w_accept[t] ? w_price[t] : '0;
        else if (w_accept[t])
          r_bill[t] <= w_bill_sum[t][BILL_W] ? '1 : w_bill_sum[t][BILL_W-1:0];
      end
      r_reject <= table_order_valid & ~w_accept;
    end
  end
  assign table_order_reject = r_reject;

  always_comb begin
    w_grant_valid = 1'b0;
    w_grant       = '0;
    w_idx         = 0;
    for (int unsigned n = 0; n < NUM_TABLES; n++) begin
      w_idx = (32'(r_rr) + n) % NUM_TABLES;
      if (!w_grant_valid && !w_empty[w_idx]) begin
        w_grant_valid = 1'b1;
        w_grant       = TW'(w_idx);
      end
    end
  end

  always_comb begin
    w_pop = '0;
    if ((r_state == K_IDLE) && w_grant_valid) w_pop[w_grant] = 1'b1;
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) r_state <= K_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      K_IDLE:  if (w_grant_valid) w_state_nxt = K_COOK;
      K_COOK:  if (r_cook_cnt == '0) w_state_nxt = K_DONE;
      K_DONE:  w_state_nxt = K_IDLE;
      default: w_state_nxt = K_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_rr       <= '0;
      r_serve    <= '0;
      r_item     <= '0;
      r_cook_cnt <= '0;
    end else if ((r_state == K_IDLE) && w_grant_valid) begin
      r_serve    <= w_grant;
      r_item     <= w_head[w_grant];
      r_cook_cnt <= CKW'(cook_cycles(32'(w_head[w_grant]), COOK_STEP) - 1);
      r_rr       <= (32'(w_grant) == NUM_TABLES - 1) ? '0 : w_grant + 1'b1;
    end else if ((r_state == K_COOK) && (r_cook_cnt != '0)) begin
      r_cook_cnt <= r_cook_cnt - 1'b1;
    end
  end

  always_comb begin
    table_item_ready = '0;
    ready_item       = '0;
    if (r_state == K_DONE) begin
      table_item_ready[r_serve] = 1'b1;
      ready_item                = r_item;
    end
  end
  assign kitchen_busy = (r_state != K_IDLE);

endmodule

// File: tb/tb_restaurant_order_scheduler.sv
// Directed self-checking bench for restaurant_order_scheduler at default parameters.
module tb_restaurant_order_scheduler;

  localparam int unsigned NT = 4;
  localparam int unsigned IW = 2;
  localparam int unsigned BW = 10;
  localparam int unsigned SW = 4;
  localparam int unsigned CW = 4;

  logic             clk = 1'b0;
  logic             reset_n = 1'b1;
  logic [NT*IW-1:0] table_order_item;
  logic [NT-1:0]    table_order_valid;
  logic [NT-1:0]    table_checkout;
  logic             restock_valid;
  logic [IW-1:0]    restock_item;
  logic [SW-1:0]    restock_qty;
  logic [NT-1:0]    table_order_reject;
  logic [NT*BW-1:0] table_bill;
  logic [NT*CW-1:0] table_queue_size;
  logic [NT-1:0]    table_item_ready;
  logic [IW-1:0]    ready_item;
  logic             kitchen_busy;

  int checks   = 0;
  int failures = 0;

  restaurant_order_scheduler #(
    .NUM_TABLES (4),
    .ITEM_W     (2),
    .QUEUE_DEPTH(8),
    .BILL_W     (10),
    .STOCK_W    (4),
    .INIT_STOCK (6),
    .PRICE_STEP (5),
    .COOK_STEP  (4)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .table_order_item  (table_order_item),
    .table_order_valid (table_order_valid),
    .table_checkout    (table_checkout),
    .restock_valid     (restock_valid),
    .restock_item      (restock_item),
    .restock_qty       (restock_qty),
    .table_order_reject(table_order_reject),
    .table_bill        (table_bill),
    .table_queue_size  (table_queue_size),
    .table_item_ready  (table_item_ready),
    .ready_item        (ready_item),
    .kitchen_busy      (kitchen_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] bill(input int t);
    return 32'(table_bill[t*BW +: BW]);
  endfunction

  function automatic logic [31:0] qsize(input int t);
    return 32'(table_queue_size[t*CW +: CW]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    table_order_item  = '0;
    table_order_valid = '0;
    table_checkout    = '0;
    restock_valid     = 1'b0;
    restock_item      = '0;
    restock_qty       = '0;
  endtask

  task automatic set_order(input int t, input logic [IW-1:0] item);
    table_order_valid[t]         = 1'b1;
    table_order_item[t*IW +: IW] = item;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset_n = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (3) tick();
  endtask

  initial begin
    int n;
    int rejcnt;
    int pulses;
    logic [15:0] seq;

    clear_inputs();
    #2 reset_n = 1'b0;
    repeat (3) tick();
    chk("rst_bill", 32'(table_bill), 0);
    chk("rst_qsize", 32'(table_queue_size), 0);
    chk("rst_busy", 32'(kitchen_busy), 0);
    chk("rst_ready", 32'(table_item_ready), 0);
    chk("rst_reject", 32'(table_order_reject), 0);
    reset_n = 1'b1;
    repeat (3) tick();

    // T1: single order of item 2 from table 0
    set_order(0, 2'd2);
    tick();
    clear_inputs();
    chk("t1_bill0", bill(0), 10);
    chk("t1_q0_push", qsize(0), 1);
    chk("t1_reject", 32'(table_order_reject), 0);
    tick();
    chk("t1_q0_pop", qsize(0), 0);
    chk("t1_busy", 32'(kitchen_busy), 1);
    n = 0;
    while (table_item_ready == '0 && n < 40) begin
      tick();
      n++;
    end
    chk("t1_cook_len", n, 8);
    chk("t1_ready", 32'(table_item_ready), 32'b0001);
    chk("t1_item", 32'(ready_item), 2);
    tick();
    chk("t1_pulse_once", 32'(table_item_ready), 0);
    chk("t1_idle", 32'(kitchen_busy), 0);

    // T2: same-item contention, stock of item 3 goes 6 -> 2 -> 0
    do_reset();
    for (int t = 0; t < 4; t++) set_order(t, 2'd3);
    tick();
    clear_inputs();
    chk("t2a_reject", 32'(table_order_reject), 0);
    chk("t2a_bill0", bill(0), 15);
    chk("t2a_bill3", bill(3), 15);
    chk("t2a_q2", qsize(2), 1);
    for (int t = 0; t < 4; t++) set_order(t, 2'd3);
    tick();
    clear_inputs();
    chk("t2b_reject", 32'(table_order_reject), 32'b1100);
    chk("t2b_bill0", bill(0), 30);
    chk("t2b_bill1", bill(1), 30);
    chk("t2b_bill2", bill(2), 15);
    chk("t2b_q0", qsize(0), 1);
    chk("t2b_q1", qsize(1), 2);
    set_order(0, 2'd3);
    set_order(1, 2'd1);
    set_order(2, 2'd0);
    tick();
    clear_inputs();
    chk("t2c_reject", 32'(table_order_reject), 32'b0101);
    chk("t2c_bill0", bill(0), 30);
    chk("t2c_bill1", bill(1), 35);
    chk("t2c_bill2", bill(2), 15);

    // T3: saturating restock, then table 3 fills its queue
    do_reset();
    restock_valid = 1'b1;
    restock_item  = 2'd1;
    restock_qty   = 4'd15;
    tick();
    clear_inputs();
    rejcnt = 0;
    for (int k = 1; k <= 12; k++) begin
      set_order(3, 2'd1);
      if (k == 2) set_order(2, 2'd3);
      tick();
      clear_inputs();
      rejcnt += int'(table_order_reject[3]);
      if (k == 6) begin
        chk("t3_ready", 32'(table_item_ready), 32'b1000);
        chk("t3_item", 32'(ready_item), 1);
      end
    end
    chk("t3_rejects", rejcnt, 3);
    chk("t3_q3", qsize(3), 8);
    chk("t3_bill3", bill(3), 45);
    chk("t3_q2", qsize(2), 0);

    // T4: round-robin alternation between tables 0 and 1
    do_reset();
    set_order(0, 2'd1);
    set_order(1, 2'd1);
    tick();
    set_order(0, 2'd1);
    set_order(1, 2'd1);
    tick();
    clear_inputs();
    seq = '0;
    pulses = 0;
    n = 0;
    while (pulses < 4 && n < 100) begin
      if (table_item_ready != '0) begin
        seq = {seq[11:0], table_item_ready};
        pulses++;
      end
      tick();
      n++;
    end
    chk("t4_pulses", pulses, 4);
    chk("t4_order", 32'(seq), 32'h1212);

    // T5: bill saturation and checkout with a same-cycle order
    do_reset();
    n = 0;
    while (bill(0) != 1020 && n < 3000) begin
      set_order(0, 2'd3);
      restock_valid = 1'b1;
      restock_item  = 2'd3;
      restock_qty   = 4'd1;
      tick();
      n++;
    end
    clear_inputs();
    chk("t5_reach_1020", bill(0), 1020);
    n = 0;
    while (qsize(0) == 8 && n < 40) begin
      tick();
      n++;
    end
    chk("t5_space_a", 32'(qsize(0) < 8), 1);
    set_order(0, 2'd3);
    tick();
    clear_inputs();
    chk("t5_saturate", bill(0), 1023);
    chk("t5_reject", 32'(table_order_reject), 0);
    n = 0;
    while (qsize(0) == 8 && n < 40) begin
      tick();
      n++;
    end
    chk("t5_space_b", 32'(qsize(0) < 8), 1);
    set_order(0, 2'd2);
    table_checkout[0] = 1'b1;
    tick();
    clear_inputs();
    chk("t5_checkout_order", bill(0), 10);
    table_checkout[0] = 1'b1;
    tick();
    clear_inputs();
    chk("t5_checkout", bill(0), 0);

    // T6: reset while cooking discards the item and restores stock
    do_reset();
    set_order(0, 2'd1);
    tick();
    clear_inputs();
    repeat (3) tick();
    chk("t6_busy_pre", 32'(kitchen_busy), 1);
    reset_n = 1'b0;
    #1;
    chk("t6_busy", 32'(kitchen_busy), 0);
    chk("t6_bill", 32'(table_bill), 0);
    chk("t6_qsize", 32'(table_queue_size), 0);
    chk("t6_ready", 32'(table_item_ready), 0);
    repeat (2) tick();
    reset_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (table_item_ready != '0) pulses++;
    end
    chk("t6_no_pulse", pulses, 0);
    for (int t = 0; t < 4; t++) set_order(t, 2'd1);
    tick();
    clear_inputs();
    chk("t6_stock_a", 32'(table_order_reject), 0);
    for (int t = 0; t < 3; t++) set_order(t, 2'd1);
    tick();
    clear_inputs();
    chk("t6_stock_b", 32'(table_order_reject), 32'b0100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
